// File: rtl/xgmii32_to_axis.sv
// 32-bit XGMII receive framer: Start/preamble/SFD detect, FCS strip, CRC-32 check, AXIS push.
module xgmii32_to_axis #(
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned MIN_FRAME_BYTES = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] xgmii_d_i,
  input  logic [3:0]  xgmii_c_i,
  input  logic        xgmii_valid_i,
  output logic [31:0] tdata_o,
  output logic [1:0]  tvldb_o,
  output logic        tvalid_o,
  output logic        tlast_o,
  output logic        tuser_o,
  output logic        rx_status_o,
  output logic        rx_rsp_valid_o
);

  localparam int unsigned CW = 16;
  localparam logic [31:0] START_WORD      = 32'h5555_55FB;
  localparam logic [31:0] PRE_WORD        = 32'hD555_5555;
  localparam logic [31:0] IDLE_WORD       = 32'h0707_0707;
  localparam logic [7:0]  TERM_B          = 8'hFD;
  localparam logic [7:0]  IDLE_B          = 8'h07;
  localparam logic [31:0] CRC802_3_PRESET = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL   = 32'hEDB8_8320;
  // Register value after running the CRC over payload plus a correct FCS.
  localparam logic [31:0] CRC_RESIDUE     = 32'hDEBB_20E3;

  function automatic logic [31:0] crc1B(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] crc2B(input logic [31:0] crc, input logic [15:0] data);
    return crc1B(crc1B(crc, data[7:0]), data[15:8]);
  endfunction

  function automatic logic [31:0] crc3B(input logic [31:0] crc, input logic [23:0] data);
    return crc1B(crc2B(crc, data[15:0]), data[23:16]);
  endfunction

  function automatic logic [31:0] crc4B(input logic [31:0] crc, input logic [31:0] data);
    return crc2B(crc2B(crc, data[15:0]), data[31:16]);
  endfunction

  typedef enum logic [2:0] {IDLE, PRE, DATA, FLUSH, DROP} state_t;

  state_t        state, state_nx;
  logic [31:0]   d1, d1_nx, d2, d2_nx;
  logic [1:0]    occ, occ_nx;
  logic [31:0]   crc, crc_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    flush_vldb, flush_vldb_nx;
  logic          flush_bad, flush_bad_nx;
  logic [31:0]   tdata_nx;
  logic [1:0]    tvldb_nx;
  logic          tvalid_nx, tlast_nx, tuser_nx, status_nx, rsp_nx;

  logic          any_c, is_term, above_ok, has_t, ctrl_err, all_idle, over, frame_bad;
  logic [1:0]    fc;
  logic [2:0]    nbytes;
  logic [CW:0]   cnt_sum;
  logic [CW-1:0] cnt_add;
  logic [31:0]   crc_upd;

  // Decode the incoming word: terminate lane, control errors, byte count and CRC step.
  always_comb begin
    any_c = |xgmii_c_i;
    fc    = 2'd0;
    for (int i = 3; i >= 0; i--) if (xgmii_c_i[i]) fc = 2'(i);
    is_term  = any_c && (xgmii_d_i[{fc, 3'b000} +: 8] == TERM_B);
    above_ok = 1'b1;
    has_t    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) > fc) && !(xgmii_c_i[i] && (xgmii_d_i[8*i +: 8] == IDLE_B))) above_ok = 1'b0;
      if (xgmii_c_i[i] && (xgmii_d_i[8*i +: 8] == TERM_B)) has_t = 1'b1;
    end
    ctrl_err = any_c && !(is_term && above_ok);
    all_idle = (xgmii_c_i == 4'hF) && (xgmii_d_i == IDLE_WORD);
    nbytes   = any_c ? {1'b0, fc} : 3'd4;
    cnt_sum  = {1'b0, cnt} + 17'(nbytes);
    cnt_add  = cnt_sum[CW] ? {CW{1'b1}} : cnt_sum[CW-1:0];
    over     = cnt_sum > 17'(MAX_FRAME_BYTES);
    case (nbytes)
      3'd1:    crc_upd = crc1B(crc, xgmii_d_i[7:0]);
      3'd2:    crc_upd = crc2B(crc, xgmii_d_i[15:0]);
      3'd3:    crc_upd = crc3B(crc, xgmii_d_i[23:0]);
      3'd4:    crc_upd = crc4B(crc, xgmii_d_i);
      default: crc_upd = crc;
    endcase
    frame_bad = (crc_upd != CRC_RESIDUE) || (cnt_add < 16'(MIN_FRAME_BYTES));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx      = state;
    d1_nx         = d1;
    d2_nx         = d2;
    occ_nx        = occ;
    crc_nx        = crc;
    cnt_nx        = cnt;
    flush_vldb_nx = flush_vldb;
    flush_bad_nx  = flush_bad;
    tdata_nx      = tdata_o;
    tvldb_nx      = 2'd0;
    tvalid_nx     = 1'b0;
    tlast_nx      = 1'b0;
    tuser_nx      = 1'b0;
    status_nx     = 1'b0;
    rsp_nx        = 1'b0;
    case (state)
      IDLE: begin
        if (xgmii_valid_i && (xgmii_c_i == 4'b0001) && (xgmii_d_i == START_WORD)) state_nx = PRE;
      end
      PRE: begin
        if (xgmii_valid_i) begin
          if ((xgmii_c_i == 4'b0000) && (xgmii_d_i == PRE_WORD)) begin
            state_nx = DATA;
            occ_nx   = 2'd0;
            crc_nx   = CRC802_3_PRESET;
            cnt_nx   = '0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (xgmii_valid_i) begin
          if (ctrl_err || over) begin
            if (occ == 2'd2) begin
              tdata_nx  = d2;
              tvldb_nx  = 2'd3;
              tvalid_nx = 1'b1;
              tlast_nx  = 1'b1;
              tuser_nx  = 1'b1;
            end
            rsp_nx   = 1'b1;
            state_nx = DROP;
          end else if (is_term) begin
            cnt_nx = cnt_add;
            if (occ != 2'd2) begin
              rsp_nx   = 1'b1;
              state_nx = IDLE;
            end else begin
              tdata_nx  = d2;
              tvldb_nx  = 2'd3;
              tvalid_nx = 1'b1;
              if (fc == 2'd0) begin
                tlast_nx  = 1'b1;
                tuser_nx  = frame_bad;
                rsp_nx    = 1'b1;
                status_nx = !frame_bad;
                state_nx  = IDLE;
              end else begin
                flush_vldb_nx = fc - 2'd1;
                flush_bad_nx  = frame_bad;
                state_nx      = FLUSH;
              end
            end
          end else begin
            cnt_nx = cnt_add;
            crc_nx = crc_upd;
            d1_nx  = xgmii_d_i;
            d2_nx  = d1;
            if (occ == 2'd2) begin
              tdata_nx  = d2;
              tvldb_nx  = 2'd3;
              tvalid_nx = 1'b1;
            end else begin
              occ_nx = occ + 2'd1;
            end
          end
        end
      end
      FLUSH: begin
        tdata_nx  = d1;
        tvldb_nx  = flush_vldb;
        tvalid_nx = 1'b1;
        tlast_nx  = 1'b1;
        tuser_nx  = flush_bad;
        rsp_nx    = 1'b1;
        status_nx = !flush_bad;
        state_nx  = IDLE;
      end
      DROP: begin
        if (xgmii_valid_i && (has_t || all_idle)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, delay line, CRC/counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      d1             <= '0;
      d2             <= '0;
      occ            <= '0;
      crc            <= '0;
      cnt            <= '0;
      flush_vldb     <= '0;
      flush_bad      <= 1'b0;
      tdata_o        <= '0;
      tvldb_o        <= '0;
      tvalid_o       <= 1'b0;
      tlast_o        <= 1'b0;
      tuser_o        <= 1'b0;
      rx_status_o    <= 1'b0;
      rx_rsp_valid_o <= 1'b0;
    end else begin
      state          <= state_nx;
      d1             <= d1_nx;
      d2             <= d2_nx;
      occ            <= occ_nx;
      crc            <= crc_nx;
      cnt            <= cnt_nx;
      flush_vldb     <= flush_vldb_nx;
      flush_bad      <= flush_bad_nx;
      tdata_o        <= tdata_nx;
      tvldb_o        <= tvldb_nx;
      tvalid_o       <= tvalid_nx;
      tlast_o        <= tlast_nx;
      tuser_o        <= tuser_nx;
      rx_status_o    <= status_nx;
      rx_rsp_valid_o <= rsp_nx;
    end
  end

endmodule

// File: tb/tb_xgmii32_to_axis.sv
// Randomized frame-level bench for xgmii32_to_axis with a queue-based payload model.
module tb_xgmii32_to_axis;

  localparam int MAX_B = 1518;
  localparam int MIN_B = 64;
  localparam logic [31:0] START_WORD = 32'h5555_55FB;
  localparam logic [31:0] PRE_WORD   = 32'hD555_5555;
  localparam logic [31:0] IDLE_WORD  = 32'h0707_0707;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] xd = '0;
  logic [3:0]  xc = '0;
  logic        xv = 1'b0;
  logic [31:0] tdata;
  logic [1:0]  tvldb;
  logic        tvalid, tlast, tuser, rx_status, rx_rsp_valid;

  xgmii32_to_axis #(.MAX_FRAME_BYTES(MAX_B), .MIN_FRAME_BYTES(MIN_B)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .xgmii_d_i(xd), .xgmii_c_i(xc), .xgmii_valid_i(xv),
    .tdata_o(tdata), .tvldb_o(tvldb), .tvalid_o(tvalid), .tlast_o(tlast), .tuser_o(tuser),
    .rx_status_o(rx_status), .rx_rsp_valid_o(rx_rsp_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; logic [1:0] vldb; logic last; logic user; } beat_t;
  typedef struct { logic status; logic with_beat; } rsp_t;
  beat_t exp_beats[$];
  rsp_t  exp_rsp[$];

  int n_vec = 0;
  int n_bad = 0;
  bit ignore_out = 1'b0;
  int first_beat_cyc = -1;
  int da_cyc = 0;
  int last_drive_cyc = 0;
  logic [31:0] last_tl_data = '0;
  logic [1:0]  last_tl_vldb = '0;
  bit periodic = 1'b0;
  int period_cnt = 0;
  int pause_pct = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Standard Ethernet CRC-32 over a byte list, returned as the FCS value (already inverted).
  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (q[j]) begin
      c = c ^ {24'h0, q[j]};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Output checker: every beat and every response is matched against the model queues.
  always @(negedge clk) begin
    beat_t e;
    rsp_t r;
    logic [31:0] m;
    if (rst_n && !ignore_out) begin
      if (tvalid) begin
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        if (tlast) begin
          last_tl_data = tdata;
          last_tl_vldb = tvldb;
          check("tlast_has_rsp", 64'(rx_rsp_valid), 64'd1);
        end
        if (exp_beats.size() == 0) begin
          check("unexpected_beat", 64'(tvalid), 64'd0);
        end else begin
          e = exp_beats.pop_front();
          m = '0;
          for (int i = 0; i <= int'(e.vldb); i++) m[8*i +: 8] = 8'hFF;
          check("beat_vldb", 64'(tvldb), 64'(e.vldb));
          check("beat_data", 64'(tdata & m), 64'(e.data & m));
          check("beat_last", 64'(tlast), 64'(e.last));
          if (e.last) check("beat_user", 64'(tuser), 64'(e.user));
        end
      end
      if (rx_rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 64'(rx_rsp_valid), 64'd0);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_status", 64'(rx_status), 64'(r.status));
          check("rsp_with_tlast", 64'(tvalid && tlast), 64'(r.with_beat));
        end
      end
    end
  end

  task automatic pause(input int n);
    repeat (n) begin
      xd = $urandom;
      xc = 4'($urandom);
      xv = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] c);
    if (periodic) begin
      period_cnt++;
      if (period_cnt % 64 == 0) pause(2);
    end else if (pause_pct > 0 && int'($urandom_range(99)) < pause_pct) begin
      pause(int'($urandom_range(3, 1)));
    end
    xd = d;
    xc = c;
    xv = 1'b1;
    last_drive_cyc = cyc;
    @(posedge clk); #1;
  endtask

  // Expected AXIS output of one frame, derived from its byte list and the framing rules.
  task automatic model_frame(input logic [7:0] fb[$], input int plen, input bit bad_fcs, input int err_word);
    int n, fw, k, e, nb, cum;
    bit bad;
    beat_t b;
    rsp_t r;
    n  = plen + 4;
    fw = n / 4;
    k  = n % 4;
    e  = -1;
    if (err_word >= 0) e = err_word;
    else begin
      for (int i = 0; i <= fw; i++) begin
        cum = (i < fw) ? 4 * (i + 1) : 4 * fw + k;
        if (cum > MAX_B && e < 0) e = i;
      end
    end
    if (e >= 0) begin
      for (int w = 0; w <= e - 2; w++) begin
        b.data = {fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]};
        b.vldb = 2'd3;
        b.last = (w == e - 2);
        b.user = 1'b1;
        exp_beats.push_back(b);
      end
      r.status = 1'b0;
      r.with_beat = (e >= 2);
      exp_rsp.push_back(r);
    end else if (fw < 2) begin
      r.status = 1'b0;
      r.with_beat = 1'b0;
      exp_rsp.push_back(r);
    end else begin
      bad = bad_fcs || (n < MIN_B);
      nb = (plen + 3) / 4;
      for (int bi = 0; bi < nb; bi++) begin
        b.data = {fb[4*bi+3], fb[4*bi+2], fb[4*bi+1], fb[4*bi]};
        b.vldb = 2'(((plen - 4 * bi) >= 4 ? 4 : (plen - 4 * bi)) - 1);
        b.last = (bi == nb - 1);
        b.user = bad;
        exp_beats.push_back(b);
      end
      r.status = !bad;
      r.with_beat = 1'b1;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic send_frame(input int plen, input bit incr, input bit bad_fcs, input bit bad_sfd,
                            input int err_word, input int err_lane, input bit pause_term,
                            input int abort_word);
    logic [7:0]  fb[$];
    logic [31:0] fcs, w32;
    logic [3:0]  c4;
    int fw, k;
    for (int i = 0; i < plen; i++) fb.push_back(incr ? 8'(i) : 8'($urandom));
    fcs = crc32(fb);
    for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
    if (bad_fcs) fb[plen + 1] = fb[plen + 1] ^ 8'h08;
    fw = (plen + 4) / 4;
    k  = (plen + 4) % 4;
    if (!bad_sfd && abort_word < 0) model_frame(fb, plen, bad_fcs, err_word);
    drive(START_WORD, 4'b0001);
    drive(bad_sfd ? 32'hD455_5555 : PRE_WORD, 4'b0000);
    for (int w = 0; w < fw; w++) begin
      w32 = {fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]};
      c4 = 4'b0000;
      if (w == err_word) begin
        w32[8*err_lane +: 8] = 8'hFE;
        c4[err_lane] = 1'b1;
      end
      drive(w32, c4);
      if (w == 0) da_cyc = last_drive_cyc;
      if (w == abort_word) begin
        rst_n = 1'b0;
        #1;
        check("reset_midframe_outputs",
              64'({tdata, tvldb, tvalid, tlast, tuser, rx_status, rx_rsp_valid}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(IDLE_WORD, 4'hF);
        return;
      end
    end
    w32 = IDLE_WORD;
    c4  = 4'hF;
    for (int i = 0; i < k; i++) begin
      w32[8*i +: 8] = fb[4*fw + i];
      c4[i] = 1'b0;
    end
    w32[8*k +: 8] = 8'hFD;
    if (pause_term) pause(2);
    drive(w32, c4);
    drive(IDLE_WORD, 4'hF);
    drive(IDLE_WORD, 4'hF);
  endtask

  initial begin
    logic [7:0] pin[$];
    int plen, fw, ew;
    bit bfcs, bsfd;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({tdata, tvldb, tvalid, tlast, tuser, rx_status, rx_rsp_valid}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) pin.push_back(8'h31 + 8'(i));
    check("model_crc_pin", 64'(crc32(pin)), 64'hCBF4_3926);
    drive(IDLE_WORD, 4'hF);

    // 64-byte frame: latency and last-beat literal
    first_beat_cyc = -1;
    send_frame(60, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, -1);
    check("first_beat_latency", 64'(first_beat_cyc - da_cyc), 64'd3);
    check("last_beat_64", 64'({last_tl_vldb, last_tl_data}), 64'h3_3B3A_3938);

    // 65-byte frame: flush beat with one byte
    send_frame(61, 1'b1, 1'b0, 1'b0, -1, 0, 1'b0, -1);
    check("flush_beat_65", 64'({last_tl_vldb, last_tl_data[7:0]}), 64'h0_3C);

    // 64-byte frame with one FCS bit flipped
    send_frame(60, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, -1);

    // Periodic gearbox pauses, including right before the terminate word
    periodic = 1'b1;
    period_cnt = 0;
    send_frame(400, 1'b1, 1'b0, 1'b0, -1, 0, 1'b1, -1);
    periodic = 1'b0;

    // Illegal control byte in word 8, then a clean frame
    send_frame(100, 1'b0, 1'b0, 1'b0, 8, 2, 1'b0, -1);
    send_frame(70, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1);

    // Bad SFD, runt, oversize
    send_frame(60, 1'b1, 1'b0, 1'b1, -1, 0, 1'b0, -1);
    send_frame(36, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1);
    send_frame(1596, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1);

    // Reset mid-frame, then a clean frame
    ignore_out = 1'b1;
    send_frame(200, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 20);
    ignore_out = 1'b0;
    send_frame(66, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, -1);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      pause_pct = int'($urandom_range(30));
      plen = ($urandom_range(9) == 0) ? int'($urandom_range(1530, 1505)) : int'($urandom_range(180, 1));
      bfcs = ($urandom_range(4) == 0);
      bsfd = ($urandom_range(9) == 0);
      fw = (plen + 4) / 4;
      ew = (plen < 1000 && $urandom_range(7) == 0) ? int'($urandom_range(fw - 1, 0)) : -1;
      send_frame(plen, 1'b0, bfcs, bsfd, ew, int'($urandom_range(3)), 1'b0, -1);
    end
    pause_pct = 0;

    repeat (10) @(posedge clk);
    #1;
    check("beats_drained", 64'(exp_beats.size()), 64'd0);
    check("rsp_drained", 64'(exp_rsp.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/xgmii32_to_axis.md
Name: xgmii32_to_axis

Overview:
- Receive-side counterpart of the 32-bit AXIS-to-XGMII transmit path.
- Takes 32-bit XGMII words from the RX gearbox and finds Start, preamble and SFD.
- Strips the preamble and the 4-byte FCS, checks the CRC-32, and streams the payload out on AXIS with byte-valid and error flags.
- The downstream MAC/FIFO has no backpressure; the block only ever pushes data.

Parameters:
- MAX_FRAME_BYTES, 1518: largest accepted frame, counted from the first DA byte through the last FCS byte.
- MIN_FRAME_BYTES, 64: smaller frames are flagged as runts.

Ports:
- clk_i  in  1  core clock
- rst_n_i  in  1  asynchronous active-low reset
- xgmii_d_i  in  32  XGMII data; lane0 = bits[7:0], first byte on the wire
- xgmii_c_i  in  4  XGMII control, one bit per lane
- xgmii_valid_i  in  1  gearbox word valid; 0 = pause cycle, the input word is ignored
- tdata_o  out  32  payload; byte0 in [7:0]
- tvldb_o  out  2  valid bytes minus 1 (0 = byte [7:0] only, 3 = all four bytes)
- tvalid_o  out  1  beat valid
- tlast_o  out  1  last beat of the frame
- tuser_o  out  1  frame error; meaningful only on the tlast beat
- rx_status_o  out  1  1 = frame good; valid while rx_rsp_valid_o = 1
- rx_rsp_valid_o  out  1  one-cycle pulse, concurrent with the tlast beat

Behaviour:
- Reset: every output is 0, state = IDLE, delay line empty, counters = 0. Reset is asynchronous and may be applied mid-frame: the frame is abandoned with no tlast.
- Pause cycles (xgmii_valid_i = 0): state, the delay line and the CRC all hold; no beat is emitted, except the FLUSH beat (see below).
- Start word: d = 0x555555FB, c = 4'b0001. Preamble word: d = 0xD5555555, c = 0.
- Terminate: the lowest lane k with c = 1 and byte = 0xFD. Lanes below k must have c = 0 and are data bytes, so the word carries k data bytes.
- States: IDLE, PRE, DATA, FLUSH, DROP.
- IDLE -> PRE: on a Start word; anything else is ignored.
- PRE -> DATA: on an exact preamble/SFD match.
- PRE -> IDLE: on a mismatch. The frame is silently discarded; no beat and no response.
- DATA: holds a two-word delay line (d1 newest, d2 older) so the FCS is never forwarded.
  - Each valid data word (c = 0) shifts in.
  - Once d2 is occupied, d2 is registered out as a full beat (tvldb = 3).
  - No-gap latency: payload word n appears on tdata_o in the cycle after word n+2 is presented (3 clocks).
- Terminate at k = 0: emit d2 with tlast, tvldb = 3; go to IDLE.
- Terminate at k = 1..3: emit d2 (tlast = 0); go to FLUSH.
- FLUSH: one clock, emitted regardless of xgmii_valid_i. Emits d1 with tvldb = k-1, tlast = 1; go to IDLE. A Start word arriving in the FLUSH cycle is not recognised.
- A terminate word with fewer than 8 + k total bytes buffered (frame shorter than 4 payload bytes): no beats; rx_rsp_valid_o pulses with rx_status_o = 0.
- CRC: running IEEE 802.3 CRC-32 over every byte from the first DA byte through the byte before T, using the shared crc1B/2B/3B/4B functions with preset CRC802_3_PRESET.
  - Good iff the CRC over the payload equals the received FCS in the transmit path's byte order (residue compare allowed).
  - Checked on the terminate word; the result is registered so it is ready with the tlast beat.
- Byte counter: 16-bit, counts DA..FCS bytes, saturates.
- tuser_o = 1 and rx_status_o = 0 on the tlast beat if any of:
  - CRC mismatch;
  - count < MIN_FRAME_BYTES;
  - any error event below.
- Error events in DATA:
  - control byte other than T (e.g. 0xFE, Start, Idle) in any lane;
  - non-Idle control in lanes above T;
  - count exceeding MAX_FRAME_BYTES.
- On an error event in DATA:
  - if d2 is occupied: emit d2 with tlast = 1, tuser = 1 and an rx_rsp_valid_o pulse with status 0;
  - otherwise: response pulse only.
  - Then go to DROP.
- DROP -> IDLE: on a word containing T, or on an all-Idle word (c = 4'hF, every byte 0x07).
- rx_rsp_valid_o pulses exactly once per frame that reached DATA.

Test Plan:
- 64-byte frame (60 payload bytes 0x00..0x3B, correct FCS, T in the lane0 word after the FCS) -> 15 beats, last tdata = 0x3B3A3938, tvldb = 3, tlast = 1, tuser = 0; rx_status = 1 pulse; first beat 3 clocks after the first DA word.
- 65-byte frame (T at lane 1) -> 15 full beats, then a FLUSH beat with tvldb = 0, tdata[7:0] = 0x3C, tlast = 1, tuser = 0.
- Same 64-byte frame with one FCS bit flipped -> identical beats, tuser = 1 on tlast, rx_status = 0.
- Gearbox pauses: xgmii_valid_i = 0 for 2 cycles every 66, placed mid-frame and on the terminate word -> output data identical to the no-gap run, tvalid gaps only, CRC good.
- Frame with 0xFE (c = 1) in lane 2 of word 8 -> the pending beat is emitted with tlast = 1, tuser = 1; following words are dropped until Idle; the next good frame is received cleanly.
- Bad SFD (0xD4); a 40-byte runt; a 1600-byte frame; rst_n_i asserted mid-frame -> respectively no output, tuser = 1, truncated with tuser = 1, and outputs immediately 0 with a clean next frame.
